sap_sequencer_param: RTL

//  Next-generation SAP control unit: one-hot T-state sequencer plus control-word decoder for the SAP datapath.

---
 rtl/sap_sequencer_param_if.sv | 24 ++
 rtl/sap_sequencer_param.sv | 69 ++++++
 2 files changed

// File: rtl/sap_sequencer_param_if.sv
// sap_sequencer_param_if: opcode/flag inputs and control-word outputs of the SAP sequencer
// master = sequencer side, slave = datapath/IR side.
interface sap_sequencer_param_if #(
  parameter int OPC_W     = 4,
  parameter int ALU_SEL_W = 3,
  parameter int NUM_T     = 6
);
  logic [OPC_W-1:0]     ins_in;
  logic                 zero_flag;
  logic                 carry_flag;
  logic [NUM_T-1:0]     T;
  logic                 CP, EP, EA, j;
  logic                 Lm_n, CE_n, LI_n, EI_n, LA_n, LB_n, LO_n;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic                 halted;
  modport master (
    input  ins_in, zero_flag, carry_flag,
    output T, CP, EP, EA, j, Lm_n, CE_n, LI_n, EI_n, LA_n, LB_n, LO_n, alu_sel, halted
  );
  modport slave (
    output ins_in, zero_flag, carry_flag,
    input  T, CP, EP, EA, j, Lm_n, CE_n, LI_n, EI_n, LA_n, LB_n, LO_n, alu_sel, halted
  );
endinterface

// File: rtl/sap_sequencer_param.sv
// sap_sequencer_param: one-hot T-state sequencer and control-word decoder for the SAP datapath
// Define SAP_EARLY_END_EN to return to T1 right after each instruction's last active execute state.
module sap_sequencer_param #(
  parameter int OPC_W     = 4,
  parameter int ALU_SEL_W = 3,
  parameter int NUM_T     = 6
) (
  input logic clk,
  input logic clr,
  sap_sequencer_param_if.master bus
);
  typedef enum logic {S_RUN, S_HALT} state_t;
  localparam logic [NUM_T-1:0] T1 = NUM_T'(1);
  state_t r_state, w_state_nxt;
  logic [NUM_T-1:0] r_t, w_t_nxt;
  logic [OPC_W-1:0] w_op;
  logic [ALU_SEL_W-1:0] w_sel;
  logic w_act, w_alu, w_lda, w_jmp, w_out, w_hlt, w_end;
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_RUN;
      r_t     <= T1;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end
  always_comb begin
    w_op  = bus.ins_in;
    w_sel = w_op == OPC_W'(0)  ? ALU_SEL_W'(1) :
            w_op == OPC_W'(1)  ? ALU_SEL_W'(2) :
            w_op == OPC_W'(2)  ? ALU_SEL_W'(3) :
            w_op == OPC_W'(3)  ? ALU_SEL_W'(4) :
            w_op == OPC_W'(6)  ? ALU_SEL_W'(5) :
            w_op == OPC_W'(7)  ? ALU_SEL_W'(6) :
            w_op == OPC_W'(8)  ? ALU_SEL_W'(7) : '0;
    w_alu = w_sel != '0;
    w_lda = w_op == OPC_W'(4);
    w_out = w_op == OPC_W'(14);
    w_hlt = w_op == OPC_W'(15);
    w_jmp = (w_op == OPC_W'(5)) | ((w_op == OPC_W'(9)) & bus.zero_flag) |
            ((w_op == OPC_W'(10)) & bus.carry_flag);
`ifdef SAP_EARLY_END_EN
    w_end = (r_t[3] & ~(w_alu | w_lda)) | (r_t[4] & w_lda) | r_t[5];
`else
    w_end = r_t[NUM_T-1];
`endif
    w_state_nxt = (r_state == S_RUN && r_t[3] && w_hlt) ? S_HALT : r_state;
    w_t_nxt     = w_state_nxt == S_HALT ? '0 : w_end ? T1 : {r_t[NUM_T-2:0], r_t[NUM_T-1]};
  end
  // strobes are gated by w_act so reset and halt force the inactive word
  always_comb begin
    w_act       = ~clr & (r_state == S_RUN);
    bus.T       = clr ? T1 : r_t;
    bus.halted  = ~clr & (r_state == S_HALT);
    bus.EP      = w_act & r_t[0];
    bus.CP      = w_act & r_t[1];
    bus.LI_n    = ~(w_act & r_t[2]);
    bus.Lm_n    = ~(w_act & (r_t[0] | (r_t[3] & (w_alu | w_lda))));
    bus.CE_n    = ~(w_act & (r_t[2] | (r_t[4] & (w_alu | w_lda))));
    bus.EI_n    = ~(w_act & r_t[3] & (w_alu | w_lda | w_jmp));
    bus.j       = w_act & r_t[3] & w_jmp;
    bus.EA      = w_act & r_t[3] & w_out;
    bus.LO_n    = ~(w_act & r_t[3] & w_out);
    bus.LB_n    = ~(w_act & r_t[4] & w_alu);
    bus.LA_n    = ~(w_act & ((r_t[4] & w_lda) | (r_t[5] & w_alu)));
    bus.alu_sel = (w_act & r_t[5] & w_alu) ? w_sel : '0;
  end
endmodule
